// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder slice: the sequencer state
// encoding and the default geometry used by the adder, the operand memory
// and the run controller.
package rca_pkg;

  localparam int RCA_WIDTH  = 32;  // operand / sum width
  localparam int RCA_ADDR_W = 5;   // operand memory address width
  localparam int RCA_SETTLE = 4;   // adder settle cycles before sampling

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    EMIT
  } rca_seq_state_t;

endpackage

// File: rtl/rca_settle_timer.sv
// Settle-time down counter for the adder run controller.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : reload the counter with SETTLE-1 (asserted in LOAD)
//   en         : decrement while the sequencer is settling
//   expired    : counter has reached zero (meaningful only while settling)
module rca_settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_INIT;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rca_sequencer.sv
// Run controller for the ripple-carry adder. Walks the operand memory one row
// {x, y, cin} per step, registers the row into the adder, waits SETTLE cycles,
// samples {sum, cout} and offers the result downstream over valid/ready.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start, num_rows            : begin a run of num_rows rows (IDLE only)
//   mem_addr, mem_x/y/c        : combinational operand memory read
//   add_a/b/cin, add_sum/cout  : registered adder inputs, adder outputs
//   res_valid/ready            : result handshake
//   res_sum/cout/index         : captured result and its row index
//   busy, done                 : run in progress, one-cycle completion pulse
module rca_sequencer #(
  parameter int WIDTH  = rca_pkg::RCA_WIDTH,
  parameter int ADDR_W = rca_pkg::RCA_ADDR_W,
  parameter int SETTLE = rca_pkg::RCA_SETTLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_rows,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_x,
  input  logic [WIDTH-1:0]  mem_y,
  input  logic              mem_c,
  output logic [WIDTH-1:0]  add_a,
  output logic [WIDTH-1:0]  add_b,
  output logic              add_cin,
  input  logic [WIDTH-1:0]  add_sum,
  input  logic              add_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_sum,
  output logic              res_cout,
  output logic [ADDR_W-1:0] res_index,
  output logic              busy,
  output logic              done
);

  // Imported after the parameters so the local SETTLE parameter shadows the
  // enum literal of the same name; the state is always written rca_pkg::SETTLE.
  import rca_pkg::*;

  localparam logic [ADDR_W:0] MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ROW_ONE  = (ADDR_W + 1)'(1);

  function automatic logic [ADDR_W:0] sat_rows(input logic [ADDR_W:0] n);
    return (n > MAX_ROWS) ? MAX_ROWS : n;
  endfunction

  rca_seq_state_t    state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   rows_q, rows_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;
  logic [WIDTH-1:0]  res_sum_q, res_sum_d;
  logic              res_cout_q, res_cout_d;
  logic [ADDR_W-1:0] res_index_q, res_index_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              timer_load;
  logic              timer_en;
  logic              timer_expired;
  logic [ADDR_W:0]   start_rows;
  logic              last_row;

  assign start_rows = sat_rows(num_rows);
  assign last_row   = ({1'b0, idx_q} == (rows_q - ROW_ONE));
  assign timer_load = (state_q == LOAD);
  assign timer_en   = (state_q == rca_pkg::SETTLE);

  rca_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rows_d      = rows_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_index_d = res_index_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d = start_rows;
          idx_d  = '0;
          // An empty run never leaves IDLE; it only reports completion.
          if (start_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        add_a_d   = mem_x;
        add_b_d   = mem_y;
        add_cin_d = mem_c;
        state_d   = rca_pkg::SETTLE;
      end
      rca_pkg::SETTLE: begin
        if (timer_expired) begin
          res_sum_d   = add_sum;
          res_cout_d  = add_cout;
          res_index_d = idx_q;
          res_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (last_row) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rows_q      <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_index_q <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rows_q      <= rows_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_index_q <= res_index_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = idx_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_index = res_index_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rca_sequencer.sv
// Directed bench for rca_sequencer with a behavioural operand memory and adder.
module tb_rca_sequencer;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int SETTLE = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   num_rows;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_x, mem_y;
  logic              mem_c;
  logic [WIDTH-1:0]  add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic              res_valid, res_ready, res_cout;
  logic [WIDTH-1:0]  res_sum;
  logic [ADDR_W-1:0] res_index;
  logic              busy, done;

  logic [WIDTH-1:0] mx [32];
  logic [WIDTH-1:0] my [32];
  logic             mc [32];

  always #5 clk = ~clk;

  assign mem_x = mx[mem_addr];
  assign mem_y = my[mem_addr];
  assign mem_c = mc[mem_addr];
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  rca_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_rows  (num_rows),
    .mem_addr  (mem_addr),
    .mem_x     (mem_x),
    .mem_y     (mem_y),
    .mem_c     (mem_c),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_index (res_index),
    .busy      (busy),
    .done      (done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_seen = 0;
  int valid_seen = 0;
  int busy_seen = 0;
  logic [ADDR_W-1:0] max_addr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (done === 1'b1) done_seen++;
    if (res_valid === 1'b1) valid_seen++;
    if (busy === 1'b1) busy_seen++;
    if (mem_addr > max_addr) max_addr = mem_addr;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (res_valid !== 1'b1) check({tag, "_timeout"}, 64'(res_valid), 64'd1);
  endtask

  task automatic start_run(input logic [ADDR_W:0] n);
    num_rows = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int t0;
    int prev;
    logic [WIDTH-1:0] hold_sum;

    for (int i = 0; i < 32; i++) begin
      mx[i] = '0;
      my[i] = '0;
      mc[i] = 1'b0;
    end
    reset = 1'b1;
    start = 1'b0;
    num_rows = '0;
    res_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_res_sum", 64'(res_sum), 64'd0);

    // 1: 1 + 1, single row
    mx[0] = 32'h0000_0001; my[0] = 32'h0000_0001; mc[0] = 1'b0;
    res_ready = 1'b1;
    t0 = cyc;
    start_run(6'd1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_valid("t1", 20);
    check("t1_latency", 64'(cyc - t0), 64'd6);
    check("t1_sum", 64'(res_sum), 64'h2);
    check("t1_cout", 64'(res_cout), 64'd0);
    check("t1_index", 64'(res_index), 64'd0);
    step();
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_valid_end", 64'(res_valid), 64'd0);
    step();
    check("t1_done_pulse", 64'(done), 64'd0);

    // 2: all-ones plus carry wraps to zero with carry-out
    mx[0] = 32'hFFFF_FFFF; my[0] = 32'h0000_0000; mc[0] = 1'b1;
    start_run(6'd1);
    wait_valid("t2", 20);
    check("t2_sum", 64'(res_sum), 64'h0);
    check("t2_cout", 64'(res_cout), 64'd1);
    step();
    step();

    // 3: full 32-row run; x = 0x80000000+i, y = 0x80000000, c = i[0]
    //    -> sum = i + i[0], cout = 1
    for (int i = 0; i < 32; i++) begin
      mx[i] = 32'h8000_0000 + 32'(i);
      my[i] = 32'h8000_0000;
      mc[i] = 1'(i & 1);
    end
    done_seen = 0;
    max_addr = '0;
    prev = 0;
    start_run(6'd32);
    for (int i = 0; i < 32; i++) begin
      wait_valid("t3", 20);
      check($sformatf("t3_index%0d", i), 64'(res_index), 64'(i));
      check($sformatf("t3_sum%0d", i), 64'(res_sum), 64'(i + (i & 1)));
      check($sformatf("t3_cout%0d", i), 64'(res_cout), 64'd1);
      if (i > 0) check($sformatf("t3_gap%0d", i), 64'(cyc - prev), 64'd6);
      prev = cyc;
      step();
    end
    step();
    check("t3_done_count", 64'(done_seen), 64'd1);
    check("t3_max_addr", 64'(max_addr), 64'd31);
    check("t3_idle", 64'(busy), 64'd0);

    // 4: back-pressure on row 2 of a 4-row run
    done_seen = 0;
    start_run(6'd4);
    wait_valid("t4_r0", 20); step();
    wait_valid("t4_r1", 20); step();
    res_ready = 1'b0;
    wait_valid("t4_r2", 20);
    hold_sum = res_sum;
    check("t4_r2_index", 64'(res_index), 64'd2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t4_hold_valid%0d", k), 64'(res_valid), 64'd1);
      check($sformatf("t4_hold_sum%0d", k), 64'(res_sum), 64'(hold_sum));
      check($sformatf("t4_hold_addr%0d", k), 64'(mem_addr), 64'd2);
      check($sformatf("t4_hold_add_a%0d", k), 64'(add_a), 64'h8000_0002);
      step();
    end
    res_ready = 1'b1;
    check("t4_still_valid", 64'(res_valid), 64'd1);
    step();
    check("t4_valid_drop", 64'(res_valid), 64'd0);
    check("t4_load_addr", 64'(mem_addr), 64'd3);
    step();
    check("t4_loaded_a", 64'(add_a), 64'h8000_0003);
    wait_valid("t4_r3", 20);
    check("t4_r3_index", 64'(res_index), 64'd3);
    check("t4_r3_sum", 64'(res_sum), 64'd4);
    step();
    check("t4_done", 64'(done), 64'd1);
    step();

    // 5a: empty run
    valid_seen = 0;
    busy_seen = 0;
    start_run(6'd0);
    check("t5_done", 64'(done), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    step();
    check("t5_done_pulse", 64'(done), 64'd0);
    step();
    check("t5_valid_seen", 64'(valid_seen), 64'd0);
    check("t5_busy_seen", 64'(busy_seen), 64'd0);

    // 5b: start during row 1 of a 4-row run is ignored
    done_seen = 0;
    start_run(6'd4);
    for (int i = 0; i < 4; i++) begin
      wait_valid("t5b", 20);
      check($sformatf("t5b_index%0d", i), 64'(res_index), 64'(i));
      step();
      if (i == 0) begin
        num_rows = 6'd2;
        start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    step();
    check("t5b_done_count", 64'(done_seen), 64'd1);

    // 6: reset during SETTLE of row 5
    start_run(6'd8);
    for (int i = 0; i < 5; i++) begin
      wait_valid("t6", 20);
      step();
    end
    step();
    check("t6_pre_addr", 64'(mem_addr), 64'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_valid", 64'(res_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_addr", 64'(mem_addr), 64'd0);
    check("t6_add_a", 64'(add_a), 64'd0);
    check("t6_add_cin", 64'(add_cin), 64'd0);
    check("t6_res_sum", 64'(res_sum), 64'd0);
    check("t6_res_index", 64'(res_index), 64'd0);
    check("t6_res_cout", 64'(res_cout), 64'd0);
    done_seen = 0;
    repeat (3) step();
    check("t6_no_done", 64'(done_seen), 64'd0);
    t0 = cyc;
    start_run(6'd1);
    wait_valid("t6_restart", 20);
    check("t6_restart_lat", 64'(cyc - t0), 64'd6);
    check("t6_restart_index", 64'(res_index), 64'd0);
    check("t6_restart_cout", 64'(res_cout), 64'd1);
    step();
    check("t6_restart_done", 64'(done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
